// File: rtl/a1339_sensor_emulator.sv
// A1339 angle-sensor SPI responder (mode 3) with pipelined 16-bit responses.
// Optional ANGLE_NOISE_EN adds LFSR-driven +/-1 LSB dither to the latched angle.
module a1339_sensor_emulator #(
    parameter int unsigned ANGLE_WIDTH = 12,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   ss_n,
    input  logic                   sck,
    input  logic                   mosi,
    output logic                   miso,
    output logic                   miso_oe,
    input  logic [ANGLE_WIDTH-1:0] angle,
    input  logic                   fault,
    output logic                   frame_done,
    output logic                   frame_error
);

    typedef enum logic [2:0] {StIdle, StShift, StDecode, StWait, StAbort} state_e;

    localparam logic [15:0] ErrWord = 16'h8000;

    // {EF, 0, P, 0, data} with P chosen so the whole word has odd parity
    function automatic logic [15:0] make_word(input logic ef, input logic [11:0] data);
        return {ef, 1'b0, ~(^{ef, data}), 1'b0, data};
    endfunction

    logic [SYNC_STAGES-1:0] sck_sync, ss_sync, mosi_sync;
    logic                   sck_prev, ss_prev;
    logic                   sck_s, ss_s, mosi_s;
    logic                   sck_rise, sck_fall, ss_rise, ss_fall;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sck_sync  <= '1;
            ss_sync   <= '1;
            mosi_sync <= '0;
            sck_prev  <= 1'b1;
            ss_prev   <= 1'b1;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            sck_prev  <= sck_s;
            ss_prev   <= ss_s;
        end
    end

    assign sck_s    = sck_sync[SYNC_STAGES-1];
    assign ss_s     = ss_sync[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync[SYNC_STAGES-1];
    assign sck_rise = ~sck_prev & sck_s;
    assign sck_fall = sck_prev & ~sck_s;
    assign ss_rise  = ~ss_prev & ss_s;
    assign ss_fall  = ss_prev & ~ss_s;
    assign miso_oe  = ~ss_s;

    state_e                 state_q, state_d;
    logic [4:0]             cnt_q, cnt_d;
    logic [15:0]            rx_q, rx_d, tx_q, tx_d, resp_q, resp_d;
    logic [7:0]             scratch_q, scratch_d;
    logic                   parity_err_q, parity_err_d, frame_abort_q, frame_abort_d;
    logic [ANGLE_WIDTH-1:0] angle_q, angle_d, angle_sample;
    logic                   miso_q, miso_d, frame_done_q, frame_done_d;
    logic                   frame_error_q, frame_error_d;
    logic                   frame_start;
    logic [11:0]            angle_ext;

    assign frame_start = (state_q == StIdle) && ss_fall;
    assign angle_ext   = 12'(angle_q);

`ifdef ANGLE_NOISE_EN
    logic [15:0]            lfsr_q;
    logic [ANGLE_WIDTH-1:0] noise;

    always_comb begin
        noise = '0;
        if (lfsr_q[1:0] == 2'b01) noise = {{(ANGLE_WIDTH-1){1'b0}}, 1'b1};
        if (lfsr_q[1:0] == 2'b10) noise = '1;
    end

    assign angle_sample = angle + noise;

    // Galois form, taps 16,14,13,11
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lfsr_q <= 16'hACE1;
        end else if (frame_start) begin
            lfsr_q <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
        end
    end
`else
    assign angle_sample = angle;
`endif

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        rx_d          = rx_q;
        tx_d          = tx_q;
        resp_d        = resp_q;
        scratch_d     = scratch_q;
        parity_err_d  = parity_err_q;
        frame_abort_d = frame_abort_q;
        angle_d       = angle_q;
        miso_d        = miso_q;
        frame_done_d  = 1'b0;
        frame_error_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (ss_fall) begin
                    angle_d = angle_sample;
                    tx_d    = fault ? make_word(1'b1, resp_q[11:0]) : resp_q;
                    cnt_d   = '0;
                    state_d = StShift;
                end
            end
            StShift: begin
                if (sck_fall) begin
                    miso_d = tx_q[15];
                    tx_d   = {tx_q[14:0], 1'b0};
                end
                if (sck_rise) begin
                    rx_d  = {rx_q[14:0], mosi_s};
                    cnt_d = cnt_q + 5'd1;
                end
                if (sck_rise && cnt_q == 5'd15) begin
                    state_d = StDecode;
                end else if (ss_rise) begin
                    state_d = StAbort;
                end
            end
            StDecode: begin
                state_d = StWait;
                if (!(^rx_q)) begin
                    parity_err_d  = 1'b1;
                    frame_error_d = 1'b1;
                    resp_d        = ErrWord;
                end else begin
                    frame_done_d = 1'b1;
                    resp_d       = ErrWord;
                    if (!rx_q[15] && rx_q[13:8] == 6'h20) begin
                        resp_d = make_word(1'b0, angle_ext);
                    end else if (!rx_q[15] && rx_q[13:8] == 6'h24) begin
                        resp_d = make_word(1'b0, {9'b0, fault, frame_abort_q, parity_err_q});
                        parity_err_d  = 1'b0;
                        frame_abort_d = 1'b0;
                    end else if (rx_q[13:8] == 6'h30) begin
                        if (rx_q[15]) begin
                            scratch_d = rx_q[7:0];
                            resp_d    = make_word(1'b0, {4'b0, rx_q[7:0]});
                        end else begin
                            resp_d = make_word(1'b0, {4'b0, scratch_q});
                        end
                    end
                end
            end
            StWait: begin
                if (ss_s) state_d = StIdle;
            end
            StAbort: begin
                frame_abort_d = 1'b1;
                frame_error_d = 1'b1;
                resp_d        = ErrWord;
                state_d       = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            rx_q          <= '0;
            tx_q          <= '0;
            resp_q        <= '0;
            scratch_q     <= '0;
            parity_err_q  <= 1'b0;
            frame_abort_q <= 1'b0;
            angle_q       <= '0;
            miso_q        <= 1'b1;
            frame_done_q  <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            rx_q          <= rx_d;
            tx_q          <= tx_d;
            resp_q        <= resp_d;
            scratch_q     <= scratch_d;
            parity_err_q  <= parity_err_d;
            frame_abort_q <= frame_abort_d;
            angle_q       <= angle_d;
            miso_q        <= miso_d;
            frame_done_q  <= frame_done_d;
            frame_error_q <= frame_error_d;
        end
    end

    assign miso        = miso_q;
    assign frame_done  = frame_done_q;
    assign frame_error = frame_error_q;

endmodule
